// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache controller slice.
//  - XLEN_DEF     : address width used across the fetch/Imem interface
//  - MEM_TAG_W    : width of memory bus transaction tags
//  - BUS_COMMAND  : memory bus command encoding
//  - ICACHE_LINE  : one cache line as read out of the line array
//  - icache_state_e : controller FSM states
package icache_ctrl_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned MEM_TAG_W = 4;
  localparam int unsigned BLOCK_W   = 64;
  // Widest tag possible (NUM_LINES >= 2); narrower tags are zero-extended into it.
  localparam int unsigned TAG_MAX_W = XLEN_DEF - 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [BLOCK_W-1:0]   data;
  } ICACHE_LINE;

  typedef enum logic {
    StIdle,
    StWait
  } icache_state_e;

endpackage

// File: rtl/icache_ctrl_if.sv
// Tagged memory bus between the instruction cache and the memory arbiter.
//  master (cache)  : drives proc2Imem_command / proc2Imem_addr,
//                    receives Imem2proc_response / Imem2proc_data / Imem2proc_tag
//  slave  (memory) : the mirror view
interface icache_ctrl_if #(
  parameter int unsigned XLEN = icache_ctrl_pkg::XLEN_DEF
);
  import icache_ctrl_pkg::*;

  BUS_COMMAND             proc2Imem_command;
  logic [XLEN-1:0]        proc2Imem_addr;
  logic [MEM_TAG_W-1:0]   Imem2proc_response;
  logic [BLOCK_W-1:0]     Imem2proc_data;
  logic [MEM_TAG_W-1:0]   Imem2proc_tag;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

endinterface

// File: rtl/icache_ctrl_mem.sv
// Direct-mapped line array for the instruction cache.
//  clock, reset : clock and synchronous active-high reset (clears valid bits only)
//  i_wr_*       : single fill write port (index, tag, 64-bit block)
//  i_rd_idx     : combinational read index
//  o_rd_line    : line at i_rd_idx, tag zero-extended to TAG_MAX_W
module icache_ctrl_mem
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output ICACHE_LINE         o_rd_line
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [BLOCK_W-1:0]   r_data [NUM_LINES];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_line       = '0;
    o_rd_line.valid = r_valid[i_rd_idx];
    o_rd_line.tag   = TAG_MAX_W'(r_tag[i_rd_idx]);
    o_rd_line.data  = r_data[i_rd_idx];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction cache controller: serves 64-bit blocks to fetch from a direct-mapped cache and
// refills misses over the tagged memory bus, one outstanding request at a time.
//  clock, reset      : clock and synchronous active-high reset
//  proc2Icache_addr  : fetch block address (bits [2:0] ignored)
//  Icache_data_out   : block for proc2Icache_addr, 0 when not valid
//  Icache_valid_out  : hit, or bypass of the block returning this cycle
//  icache_bus_idle   : no command on the memory bus this cycle
//  io_imem           : memory bus (master side)
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [XLEN-1:0]    proc2Icache_addr,
  output logic [BLOCK_W-1:0] Icache_data_out,
  output logic               Icache_valid_out,
  output logic               icache_bus_idle,
  icache_ctrl_if.master      io_imem
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = XLEN - 3 - IDX_W;
  localparam int unsigned BLK_W = XLEN - 3;

  icache_state_e        r_state;
  logic [MEM_TAG_W-1:0] r_pend_tag;
  logic [BLK_W-1:0]     r_pend_blk;

  logic [BLK_W-1:0] w_blk;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_unused_offset;
  ICACHE_LINE       w_line;
  logic             w_hit;
  logic             w_ret;
  logic             w_byp;
  logic             w_miss_req;

  assign w_blk           = proc2Icache_addr[XLEN-1:3];
  assign w_idx           = proc2Icache_addr[3 +: IDX_W];
  assign w_tag           = proc2Icache_addr[XLEN-1:3+IDX_W];
  assign w_unused_offset = ^proc2Icache_addr[2:0];

  icache_ctrl_mem #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_mem (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_ret),
    .i_wr_idx  (r_pend_blk[IDX_W-1:0]),
    .i_wr_tag  (r_pend_blk[BLK_W-1:IDX_W]),
    .i_wr_data (io_imem.Imem2proc_data),
    .i_rd_idx  (w_idx),
    .o_rd_line (w_line)
  );

  assign w_hit = w_line.valid && (w_line.tag == TAG_MAX_W'(w_tag));
  // Pending tag is never 0, so an idle bus (tag 0) can never look like a return.
  assign w_ret = (r_state == StWait) && (io_imem.Imem2proc_tag == r_pend_tag);
  assign w_byp = w_ret && (w_blk == r_pend_blk);
  // Outputs are forced to their reset values while reset is held.
  assign w_miss_req = !reset && (r_state == StIdle) && !w_hit;

  always_comb begin
    Icache_valid_out = 1'b0;
    Icache_data_out  = '0;
    if (!reset) begin
      if (w_byp) begin
        Icache_valid_out = 1'b1;
        Icache_data_out  = io_imem.Imem2proc_data;
      end else if (w_hit) begin
        Icache_valid_out = 1'b1;
        Icache_data_out  = w_line.data;
      end
    end
  end

  always_comb begin
    io_imem.proc2Imem_command = BUS_NONE;
    io_imem.proc2Imem_addr    = '0;
    if (w_miss_req) begin
      io_imem.proc2Imem_command = BUS_LOAD;
      io_imem.proc2Imem_addr    = {w_blk, 3'b000};
    end
  end

  assign icache_bus_idle = (io_imem.proc2Imem_command == BUS_NONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_pend_tag <= '0;
      r_pend_blk <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_miss_req && (io_imem.Imem2proc_response != '0)) begin
            r_state    <= StWait;
            r_pend_tag <= io_imem.Imem2proc_response;
            r_pend_blk <= w_blk;
          end
        end
        StWait: begin
          if (w_ret) begin
            r_state    <= StIdle;
            r_pend_tag <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios then randomized fetch/memory traffic, every cycle
// compared against a block-address-level model of the cache and its single pending request.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int unsigned NL    = 32;
  localparam int unsigned XL    = 32;
  localparam int unsigned IDX_W = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [63:0] dout;
  logic        vout;
  logic        idle;

  always #5 clock = ~clock;

  icache_ctrl_if #(.XLEN(XL)) bus ();

  icache_ctrl #(
    .NUM_LINES (NL),
    .XLEN      (XL)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2Icache_addr (fetch_addr),
    .Icache_data_out  (dout),
    .Icache_valid_out (vout),
    .icache_bus_idle  (idle),
    .io_imem          (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what each line holds, by full block address, plus the one outstanding request.
  bit          m_valid [NL];
  logic [28:0] m_blk   [NL];
  logic [63:0] m_data  [NL];
  bit          m_pend;
  logic [3:0]  m_ptag;
  logic [28:0] m_pblk;

  // Memory side: one scheduled return at a time.
  bit          mem_busy;
  int          mem_cnt;
  logic [3:0]  mem_tag;
  logic [63:0] mem_dat;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rst, input logic [31:0] a, input logic [3:0] rtag,
                       input logic [63:0] rdat, input logic [3:0] resp, output bit accepted);
    logic [28:0] blk;
    logic [4:0]  idx;
    bit          hit, ret, byp, load;
    logic        e_v;
    logic [63:0] e_d;
    logic [31:0] e_a;
    reset                  = rst;
    fetch_addr             = a;
    bus.Imem2proc_tag      = rtag;
    bus.Imem2proc_data     = rdat;
    bus.Imem2proc_response = resp;
    #2;
    blk  = a[31:3];
    idx  = blk[IDX_W-1:0];
    hit  = m_valid[idx] && (m_blk[idx] == blk);
    ret  = m_pend && (rtag == m_ptag);
    byp  = ret && (blk == m_pblk);
    load = !rst && !m_pend && !hit;
    e_v  = !rst && (hit || byp);
    e_d  = rst ? 64'h0 : byp ? rdat : hit ? m_data[idx] : 64'h0;
    e_a  = load ? {blk, 3'b000} : 32'h0;
    check_eq("valid_out", 64'(vout), 64'(e_v));
    check_eq("data_out", dout, e_d);
    check_eq("command", 64'(bus.proc2Imem_command), load ? 64'd1 : 64'd0);
    check_eq("mem_addr", 64'(bus.proc2Imem_addr), 64'(e_a));
    check_eq("bus_idle", 64'(idle), 64'(!load));
    accepted = 1'b0;
    if (rst) begin
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_pend = 1'b0;
    end else if (ret) begin
      m_valid[m_pblk[IDX_W-1:0]] = 1'b1;
      m_blk[m_pblk[IDX_W-1:0]]   = m_pblk;
      m_data[m_pblk[IDX_W-1:0]]  = rdat;
      m_pend = 1'b0;
    end else if (load && resp != 4'd0) begin
      m_pend   = 1'b1;
      m_ptag   = resp;
      m_pblk   = blk;
      accepted = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit          acc;
    logic [31:0] a;
    logic [3:0]  rtag, resp;
    logic [63:0] rdat;
    bit          rst;

    reset = 1'b1;
    fetch_addr = '0;
    bus.Imem2proc_tag = '0;
    bus.Imem2proc_data = '0;
    bus.Imem2proc_response = '0;
    m_pend = 1'b0;
    mem_busy = 1'b0;
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    @(posedge clock);
    #1;

    // Reset values.
    cycle(1, 32'h0, 4'd0, 64'h0, 4'd0, acc);
    cycle(1, 32'h0, 4'd0, 64'h0, 4'd0, acc);

    // Cold miss at 0x0, accepted with tag 3, returns 4 cycles later; stray tag 7 while idle.
    cycle(0, 32'h0, 4'd0, 64'h0, 4'd3, acc);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h0, 4'd3, 64'hDEAD_BEEF_0000_0013, 4'd0, acc);
    check_eq("cold_bypass_data", dout, 64'hDEAD_BEEF_0000_0013);
    cycle(0, 32'h4, 4'd7, 64'h1111_2222_3333_4444, 4'd0, acc);
    cycle(0, 32'h0, 4'd0, 64'h0, 4'd0, acc);

    // Conflict: 0x100 shares index 0, refills it; stray tag 7 during its WAIT.
    cycle(0, 32'h100, 4'd0, 64'h0, 4'd1, acc);
    cycle(0, 32'h100, 4'd7, 64'h5555_5555_5555_5555, 4'd0, acc);
    cycle(0, 32'h100, 4'd1, 64'h0000_0100_0000_0100, 4'd0, acc);
    cycle(0, 32'h100, 4'd0, 64'h0, 4'd0, acc);

    // 0x0 misses again; redirect to 0x40 while waiting on tag 2.
    cycle(0, 32'h0, 4'd0, 64'h0, 4'd2, acc);
    cycle(0, 32'h40, 4'd7, 64'h7777_7777_7777_7777, 4'd0, acc);
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd9, acc);
    cycle(0, 32'h40, 4'd2, 64'h0000_0000_2222_0000, 4'd0, acc);
    cycle(0, 32'h0, 4'd0, 64'h0, 4'd0, acc);

    // Rejection twice, then accepted with tag 5.
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd5, acc);
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h40, 4'd5, 64'h0000_0040_0000_0040, 4'd0, acc);
    cycle(0, 32'h40, 4'd0, 64'h0, 4'd0, acc);

    // Reset during WAIT on tag 4; the late tag 4 must not fill.
    cycle(0, 32'h8, 4'd0, 64'h0, 4'd4, acc);
    cycle(1, 32'h8, 4'd0, 64'h0, 4'd0, acc);
    cycle(1, 32'h8, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h8, 4'd4, 64'hBAD0_BAD0_BAD0_BAD0, 4'd0, acc);
    cycle(0, 32'h8, 4'd0, 64'h0, 4'd0, acc);
    cycle(0, 32'h0, 4'd0, 64'h0, 4'd0, acc);

    // Randomized traffic over a small address pool to force hits, conflicts and redirects.
    a = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 3)
        a = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      rtag = 4'd0;
      rdat = {$urandom, $urandom};
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rtag     = mem_tag;
          rdat     = mem_dat;
          mem_busy = 1'b0;
        end
      end
      if (rtag == 4'd0 && $urandom_range(0, 4) == 0) begin
        rtag = 4'($urandom_range(1, 15));
        if (mem_busy && rtag == mem_tag) rtag = 4'd0;
      end
      if (mem_busy && !m_pend) resp = 4'd0;
      else if ($urandom_range(0, 2) == 0) resp = 4'd0;
      else resp = 4'($urandom_range(1, 15));
      cycle(rst, a, rtag, rdat, resp, acc);
      if (acc) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(1, 5);
        mem_tag  = resp;
        mem_dat  = {$urandom, $urandom};
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
